// File: rtl/ipm_xy_port.sv
// Input port of the asynchronous-NoC switch: two-phase upstream channel into a FIFO,
// XY route decode of the head flit, and wormhole forwarding to one two-phase output.
module ipm_xy_port #(
  parameter int         WORD_WIDTH = 32,
  parameter int         DEPTH      = 4,
  parameter int         NLOCAL     = 1,
  parameter logic [3:0] MY_X       = 4'd0,
  parameter logic [3:0] MY_Y       = 4'd0,
  localparam int        OUTPORTS   = 4 + NLOCAL
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_up_i,
  input  logic [WORD_WIDTH-1:0]          Data_up_i,
  output logic                           ack_up_o,
  output logic [OUTPORTS-1:0]            req_dw_o,
  output logic [OUTPORTS*WORD_WIDTH-1:0] Data_dw_o,
  input  logic [OUTPORTS-1:0]            ack_dw_i,
  input  logic [OUTPORTS-1:0]            Tailpassed_dw_i,
  output logic [OUTPORTS-1:0]            PacketEnable_dw_o,
  output logic [7:0]                     drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(OUTPORTS);

  typedef enum logic [2:0] {IDLE, ROUTE, SEND, WAIT_ACK, DROP} state_e;

  logic                  req_meta_q, req_sync_q;
  logic [OUTPORTS-1:0]   ack_meta_q, ack_sync_q;
  logic [OUTPORTS-1:0]   tp_meta_q, tp_sync_q;

  logic                  ack_up_q, ack_up_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [WORD_WIDTH-1:0] fifo_mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [PW-1:0]         port_q, port_d;
  logic                  route_ok_q, route_ok_d;
  logic [1:0]            last_type_q, last_type_d;
  logic [OUTPORTS-1:0]   req_dw_q, req_dw_d;
  logic [OUTPORTS-1:0]   pe_q, pe_d;
  logic [WORD_WIDTH-1:0] data_dw_q [OUTPORTS];
  logic [WORD_WIDTH-1:0] data_dw_d [OUTPORTS];
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic                  empty, full, wr_en, pop, bump_drop;
  logic [WORD_WIDTH-1:0] fifo_head;
  logic [1:0]            head_type;
  logic [3:0]            dest_x, dest_y;
  logic [2:0]            dest_loc;
  logic [PW-1:0]         route_port;
  logic                  route_valid;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en     = (req_sync_q != ack_up_q) && !full;
  assign fifo_head = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign head_type = fifo_head[1:0];
  assign dest_x    = fifo_head[12:9];
  assign dest_y    = fifo_head[8:5];
  assign dest_loc  = fifo_head[4:2];

  // Dimension-ordered XY: resolve X first, then Y, then eject locally.
  always_comb begin
    route_port  = '0;
    route_valid = 1'b1;
    if (dest_x > MY_X) begin
      route_port = PW'(0);
    end else if (dest_x < MY_X) begin
      route_port = PW'(1);
    end else if (dest_y > MY_Y) begin
      route_port = PW'(2);
    end else if (dest_y < MY_Y) begin
      route_port = PW'(3);
    end else begin
      route_port  = PW'(4 + 32'(dest_loc));
      route_valid = (32'(dest_loc) < NLOCAL);
    end
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    route_ok_d  = route_ok_q;
    last_type_d = last_type_q;
    req_dw_d    = req_dw_q;
    pe_d        = pe_q;
    data_dw_d   = data_dw_q;
    drop_cnt_d  = drop_cnt_q;
    pop         = 1'b0;
    bump_drop   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_type[0]) begin
            port_d     = route_port;
            route_ok_d = route_valid;
            state_d    = ROUTE;
          end else begin
            pop       = 1'b1;
            bump_drop = 1'b1;
          end
        end
      end
      // The head stays in the FIFO until it is actually sent or discarded.
      ROUTE: begin
        if (!route_ok_q) begin
          bump_drop = 1'b1;
          if (head_type == 2'b11) begin
            pop     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end else if (tp_sync_q[port_q]) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (!empty) begin
          data_dw_d[port_q] = fifo_head;
          req_dw_d[port_q]  = ~req_dw_q[port_q];
          pe_d[port_q]      = 1'b1;
          last_type_d       = head_type;
          pop               = 1'b1;
          state_d           = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_sync_q[port_q] == req_dw_q[port_q]) begin
          if (last_type_q[1]) begin
            pe_d[port_q] = 1'b0;
            state_d      = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      DROP: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_type == 2'b10) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bump_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  assign ack_up_d = wr_en ? ~ack_up_q : ack_up_q;
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      req_meta_q  <= 1'b0;
      req_sync_q  <= 1'b0;
      ack_meta_q  <= '0;
      ack_sync_q  <= '0;
      tp_meta_q   <= '0;
      tp_sync_q   <= '0;
      ack_up_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      port_q      <= '0;
      route_ok_q  <= 1'b0;
      last_type_q <= 2'b00;
      req_dw_q    <= '0;
      pe_q        <= '0;
      drop_cnt_q  <= 8'd0;
      for (int p = 0; p < OUTPORTS; p++) data_dw_q[p] <= '0;
    end else begin
      req_meta_q  <= req_up_i;
      req_sync_q  <= req_meta_q;
      ack_meta_q  <= ack_dw_i;
      ack_sync_q  <= ack_meta_q;
      tp_meta_q   <= Tailpassed_dw_i;
      tp_sync_q   <= tp_meta_q;
      ack_up_q    <= ack_up_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      port_q      <= port_d;
      route_ok_q  <= route_ok_d;
      last_type_q <= last_type_d;
      req_dw_q    <= req_dw_d;
      pe_q        <= pe_d;
      drop_cnt_q  <= drop_cnt_d;
      data_dw_q   <= data_dw_d;
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) fifo_mem_q[wr_ptr_q[AW-1:0]] <= Data_up_i;
  end

  assign ack_up_o          = ack_up_q;
  assign req_dw_o          = req_dw_q;
  assign PacketEnable_dw_o = pe_q;
  assign drop_cnt_o        = drop_cnt_q;

  for (genvar p = 0; p < OUTPORTS; p++) begin : g_data_out
    assign Data_dw_o[p*WORD_WIDTH +: WORD_WIDTH] = data_dw_q[p];
  end

endmodule

// File: tb/tb_ipm_xy_port.sv
// Directed bench for ipm_xy_port at router (2,2) with one local port: routing, wormhole
// forwarding, back-pressure, drop counting with saturation, and mid-packet reset.
module tb_ipm_xy_port;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_up_i = 1'b0;
  logic [31:0]  Data_up_i = '0;
  logic         ack_up_o;
  logic [4:0]   req_dw_o;
  logic [159:0] Data_dw_o;
  logic [4:0]   ack_dw_i = '0;
  logic [4:0]   Tailpassed_dw_i = 5'b11111;
  logic [4:0]   PacketEnable_dw_o;
  logic [7:0]   drop_cnt_o;

  int n_checks = 0;
  int n_fails  = 0;

  int          out_n = 0;
  int          ack_cnt = 0;
  int          log_port [64];
  logic [31:0] log_data [64];
  logic        log_pe   [64];
  logic [4:0]  req_prev = '0;
  logic        ack_up_prev = 1'b0;

  ipm_xy_port #(
    .WORD_WIDTH(32), .DEPTH(4), .NLOCAL(1), .MY_X(4'd2), .MY_Y(4'd2)
  ) dut (
    .clk(clk), .reset(reset), .req_up_i(req_up_i), .Data_up_i(Data_up_i),
    .ack_up_o(ack_up_o), .req_dw_o(req_dw_o), .Data_dw_o(Data_dw_o),
    .ack_dw_i(ack_dw_i), .Tailpassed_dw_i(Tailpassed_dw_i),
    .PacketEnable_dw_o(PacketEnable_dw_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Downstream model: logs every request toggle and acknowledges it straight away.
  always @(negedge clk) begin
    if (reset) begin
      req_prev    = req_dw_o;
      ack_up_prev = ack_up_o;
    end else begin
      if (ack_up_o !== ack_up_prev) begin
        ack_cnt++;
        ack_up_prev = ack_up_o;
      end
      for (int p = 0; p < 5; p++) begin
        if (req_dw_o[p] !== req_prev[p]) begin
          if (out_n < 64) begin
            log_port[out_n] = p;
            log_data[out_n] = Data_dw_o[p*32 +: 32];
            log_pe[out_n]   = PacketEnable_dw_o[p];
          end
          out_n++;
          req_prev[p] = req_dw_o[p];
        end
      end
    end
    ack_dw_i = req_dw_o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    n_checks++;
    n_fails++;
    $error("[TB] FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic applyStimulus(input logic [31:0] flit);
    int budget = 0;
    @(negedge clk);
    while (ack_up_o !== req_up_i && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) timeoutFail("upstream_ack_wait");
    Data_up_i = flit;
    req_up_i  = ~req_up_i;
  endtask

  task automatic waitDelivered(input int n);
    int budget = 0;
    while (out_n < n && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (out_n < n) timeoutFail("delivery_wait");
  endtask

  function automatic logic [31:0] mkHead(input logic [3:0] x, input logic [3:0] y,
                                         input logic [2:0] loc, input logic [1:0] typ,
                                         input logic [7:0] tag);
    return {11'h0, tag, x, y, loc, typ};
  endfunction

  function automatic logic [31:0] mkBody(input logic [1:0] typ, input logic [7:0] tag);
    return {22'h0, tag, typ};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] pkt [5];
    int base_ack;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_ack_up", ack_up_o, 0);
    checkOutput("reset_req_dw", req_dw_o, 0);
    checkOutput("reset_pe", PacketEnable_dw_o, 0);
    checkOutput("reset_data_dw", |Data_dw_o, 0);
    checkOutput("reset_drop_cnt", drop_cnt_o, 0);

    // Four-flit packet east, with input and forwarding latency checks on the head.
    pkt[0] = mkHead(4'd3, 4'd2, 3'd0, 2'b01, 8'hA0);
    pkt[1] = mkBody(2'b00, 8'hA1);
    pkt[2] = mkBody(2'b00, 8'hA2);
    pkt[3] = mkBody(2'b10, 8'hA3);
    applyStimulus(pkt[0]);
    repeat (2) @(negedge clk);
    checkOutput("ack_up_before_E3", ack_up_o, 0);
    @(negedge clk);
    checkOutput("ack_up_at_E3", ack_up_o, 1);
    repeat (2) @(negedge clk);
    checkOutput("req_dw0_before_E6", req_dw_o[0], 0);
    @(negedge clk);
    checkOutput("req_dw0_at_E6", req_dw_o[0], 1);
    for (int i = 1; i < 4; i++) applyStimulus(pkt[i]);
    waitDelivered(4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("east_port_%0d", i), log_port[i], 0);
      checkOutput($sformatf("east_data_%0d", i), log_data[i], pkt[i]);
      checkOutput($sformatf("east_pe_%0d", i), log_pe[i], 1);
    end
    repeat (8) @(negedge clk);
    checkOutput("east_pe_cleared", PacketEnable_dw_o, 0);
    checkOutput("east_req_final", req_dw_o, 5'b00000);
    checkOutput("east_count", out_n, 4);

    // Single-flit packets to W, N, S and local port 0.
    pkt[0] = mkHead(4'd1, 4'd2, 3'd0, 2'b11, 8'hB1);
    pkt[1] = mkHead(4'd2, 4'd3, 3'd0, 2'b11, 8'hB2);
    pkt[2] = mkHead(4'd2, 4'd1, 3'd0, 2'b11, 8'hB3);
    pkt[3] = mkHead(4'd2, 4'd2, 3'd0, 2'b11, 8'hB4);
    for (int i = 0; i < 4; i++) applyStimulus(pkt[i]);
    waitDelivered(8);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("single_port_%0d", i), log_port[4+i], i + 1);
      checkOutput($sformatf("single_data_%0d", i), log_data[4+i], pkt[i]);
    end
    repeat (4) @(negedge clk);
    checkOutput("single_req_final", req_dw_o, 5'b11110);
    checkOutput("single_pe_final", PacketEnable_dw_o, 0);

    // East port held busy: the FIFO fills and the fifth flit waits for space.
    Tailpassed_dw_i = 5'b11110;
    repeat (3) @(negedge clk);
    base_ack = ack_cnt;
    pkt[0] = mkHead(4'd3, 4'd2, 3'd0, 2'b01, 8'hC0);
    pkt[1] = mkBody(2'b00, 8'hC1);
    pkt[2] = mkBody(2'b00, 8'hC2);
    pkt[3] = mkBody(2'b00, 8'hC3);
    pkt[4] = mkBody(2'b10, 8'hC4);
    for (int i = 0; i < 5; i++) applyStimulus(pkt[i]);
    repeat (20) @(negedge clk);
    checkOutput("blocked_acks", ack_cnt - base_ack, 4);
    checkOutput("blocked_no_send", out_n, 8);
    checkOutput("blocked_req_dw0", req_dw_o[0], 0);
    Tailpassed_dw_i = 5'b11111;
    waitDelivered(13);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("blocked_port_%0d", i), log_port[8+i], 0);
      checkOutput($sformatf("blocked_data_%0d", i), log_data[8+i], pkt[i]);
    end
    checkOutput("blocked_acks_after", ack_cnt - base_ack, 5);

    // Local port 3 does not exist with one local port: whole packet is discarded.
    repeat (6) @(negedge clk);
    base_ack = ack_cnt;
    applyStimulus(mkHead(4'd2, 4'd2, 3'd3, 2'b01, 8'hD0));
    applyStimulus(mkBody(2'b00, 8'hD1));
    applyStimulus(mkBody(2'b10, 8'hD2));
    repeat (15) @(negedge clk);
    checkOutput("invalid_drop_cnt", drop_cnt_o, 1);
    checkOutput("invalid_acks", ack_cnt - base_ack, 3);
    checkOutput("invalid_no_send", out_n, 13);
    pkt[0] = mkHead(4'd3, 4'd2, 3'd0, 2'b11, 8'hE0);
    applyStimulus(pkt[0]);
    waitDelivered(14);
    checkOutput("after_drop_port", log_port[13], 0);
    checkOutput("after_drop_data", log_data[13], pkt[0]);

    // Stray body flit, then enough invalid packets to pin the counter at 255.
    applyStimulus(mkBody(2'b00, 8'hF0));
    repeat (8) @(negedge clk);
    checkOutput("stray_drop_cnt", drop_cnt_o, 2);
    for (int i = 0; i < 253; i++) applyStimulus(mkHead(4'd2, 4'd2, 3'd5, 2'b11, 8'(i)));
    repeat (10) @(negedge clk);
    checkOutput("drop_cnt_reaches_255", drop_cnt_o, 255);
    for (int i = 0; i < 3; i++) applyStimulus(mkHead(4'd2, 4'd2, 3'd5, 2'b11, 8'hEE));
    repeat (10) @(negedge clk);
    checkOutput("drop_cnt_saturated", drop_cnt_o, 255);
    checkOutput("saturate_no_send", out_n, 14);

    // Reset in the middle of a packet, then a fresh packet must route cleanly.
    applyStimulus(mkHead(4'd3, 4'd2, 3'd0, 2'b01, 8'h90));
    applyStimulus(mkBody(2'b00, 8'h91));
    waitDelivered(15);
    @(negedge clk);
    reset     = 1'b1;
    req_up_i  = 1'b0;
    Data_up_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_ack_up", ack_up_o, 0);
    checkOutput("midreset_req_dw", req_dw_o, 0);
    checkOutput("midreset_pe", PacketEnable_dw_o, 0);
    checkOutput("midreset_data_dw", |Data_dw_o, 0);
    checkOutput("midreset_drop_cnt", drop_cnt_o, 0);
    pkt[0] = mkHead(4'd1, 4'd2, 3'd0, 2'b11, 8'h77);
    applyStimulus(pkt[0]);
    waitDelivered(16);
    repeat (6) @(negedge clk);
    checkOutput("postreset_port", log_port[15], 1);
    checkOutput("postreset_data", log_data[15], pkt[0]);
    checkOutput("postreset_drop_cnt", drop_cnt_o, 0);
    checkOutput("postreset_req_dw", req_dw_o, 5'b00010);
    checkOutput("postreset_count", out_n, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
